gpu_fill_engine_param: RTL and testbench

//  Parametrised VRAM rectangle-fill engine (GP0 0x02 FILL). Sits between the GPU command

---
 rtl/gpu_fill_engine_param.sv | 150 +++++++++++++++
 tb/tb_gpu_fill_engine_param.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/gpu_fill_engine_param.sv
// VRAM rectangle fill: walks the latched rectangle line by line and issues block writes with
// per-pixel masks (exact or block-rounded X), X/Y wrap, interlace skip and stencil mirroring.
module gpu_fill_engine_param #(
  parameter int PIX_PER_BLK = 16,
  parameter int VRAM_W_LOG2 = 10,
  parameter int VRAM_H_LOG2 = 9,
  localparam int BLK_LOG2 = $clog2(PIX_PER_BLK),
  localparam int XB_W     = VRAM_W_LOG2 - BLK_LOG2,
  localparam int ADR_W    = XB_W + VRAM_H_LOG2
) (
  input  logic                     i_clk,
  input  logic                     i_nrst,
  input  logic                     i_activateFILL,
  input  logic                     i_exactMode,
  input  logic                     i_forceMask,
  input  logic                     i_InterlaceRender,
  input  logic                     GPU_REG_CurrentInterlaceField,
  input  logic [7:0]               RegR0,
  input  logic [7:0]               RegG0,
  input  logic [7:0]               RegB0,
  input  logic [11:0]              RegX0,
  input  logic [11:0]              RegY0,
  input  logic [10:0]              RegSizeW,
  input  logic [9:0]               RegSizeH,
  output logic                     o_FILLInactiveNextCycle,
  output logic                     o_command,
  input  logic                     i_busy,
  output logic                     o_write,
  output logic [ADR_W-1:0]         o_adr,
  output logic [PIX_PER_BLK-1:0]   o_writeMask,
  output logic [16*PIX_PER_BLK-1:0] o_dataOut,
  output logic                     o_stencilWriteSig,
  output logic [ADR_W-1:0]         o_stencilWriteAdr,
  output logic [PIX_PER_BLK-1:0]   o_stencilWriteValue,
  output logic [PIX_PER_BLK-1:0]   o_stencilWriteMask
);
  localparam int BC_W = 13 - BLK_LOG2;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_LINE, S_ISSUE, S_DONE} state_t;
  state_t state, state_nxt;

  logic [VRAM_W_LOG2-1:0] x0;
  logic [VRAM_H_LOG2-1:0] y0, y_cur, y_calc;
  logic [10:0] w;
  logic [9:0]  h, line;
  logic [15:0] pix;
  logic        exact, force_bit, interlace, field;
  logic [12:0] xs, xe, x13, xe_m1, px;
  logic [BC_W-1:0] blk, blk_first, blk_last;
  logic        accept, last_line, last_blk, skip;
  logic        unused_bits;

  // Only the low address bits and the top 5 colour bits take part in the fill.
  assign unused_bits = ^{RegX0[11:VRAM_W_LOG2], RegY0[11:VRAM_H_LOG2],
                         RegR0[2:0], RegG0[2:0], RegB0[2:0]};

  assign x13       = 13'(x0);
  assign xe_m1     = xe - 13'd1;
  assign blk_first = BC_W'(xs >> BLK_LOG2);
  assign blk_last  = BC_W'(xe_m1 >> BLK_LOG2);
  assign y_calc    = y0 + VRAM_H_LOG2'(line);
  assign skip      = interlace && (y_calc[0] == field);
  assign last_line = (line == h - 10'd1);
  assign last_blk  = (blk == blk_last);
  assign accept    = (state == S_ISSUE) && !i_busy;

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) state <= S_IDLE;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (i_activateFILL) state_nxt = S_SETUP;
      S_SETUP: state_nxt = (w == 11'd0 || h == 10'd0) ? S_DONE : S_LINE;
      S_LINE: begin
        if (!skip)          state_nxt = S_ISSUE;
        else if (last_line) state_nxt = S_DONE;
      end
      S_ISSUE: if (accept && last_blk) state_nxt = last_line ? S_DONE : S_LINE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      x0 <= '0; y0 <= '0; w <= '0; h <= '0; pix <= '0;
      exact <= 1'b0; force_bit <= 1'b0; interlace <= 1'b0; field <= 1'b0;
      xs <= '0; xe <= '0; line <= '0; y_cur <= '0; blk <= '0;
    end else begin
      case (state)
        S_IDLE: if (i_activateFILL) begin
          x0        <= RegX0[VRAM_W_LOG2-1:0];
          y0        <= RegY0[VRAM_H_LOG2-1:0];
          w         <= RegSizeW;
          h         <= RegSizeH;
          pix       <= {i_forceMask, RegB0[7:3], RegG0[7:3], RegR0[7:3]};
          exact     <= i_exactMode;
          force_bit <= i_forceMask;
          interlace <= i_InterlaceRender;
          field     <= GPU_REG_CurrentInterlaceField;
        end
        S_SETUP: begin
          line <= '0;
          if (exact) begin
            xs <= x13;
            xe <= x13 + 13'(w);
          end else begin
            xs <= x13 & ~13'(PIX_PER_BLK - 1);
            xe <= (x13 + 13'(w) + 13'(PIX_PER_BLK - 1)) & ~13'(PIX_PER_BLK - 1);
          end
        end
        S_LINE: begin
          y_cur <= y_calc;
          blk   <= blk_first;
          if (skip) line <= line + 10'd1;
        end
        S_ISSUE: if (accept) begin
          if (last_blk) line <= line + 10'd1;
          else          blk  <= blk + BC_W'(1);
        end
        default: ;
      endcase
    end
  end

  // Mask uses unwrapped pixel coordinates; rounded bounds make every bit set in block mode.
  always_comb begin
    o_writeMask = '0;
    px          = '0;
    if (state == S_ISSUE) begin
      for (int p = 0; p < PIX_PER_BLK; p++) begin
        px = {blk, BLK_LOG2'(p)};
        o_writeMask[p] = (px >= xs) && (px < xe);
      end
    end
  end

  assign o_command               = (state == S_ISSUE);
  assign o_write                 = o_command;
  assign o_adr                   = o_command ? {y_cur, blk[XB_W-1:0]} : '0;
  assign o_dataOut               = o_command ? {PIX_PER_BLK{pix}} : '0;
  assign o_FILLInactiveNextCycle = ((state == S_IDLE) && !i_activateFILL) || (state == S_DONE);
  assign o_stencilWriteSig       = accept;
  assign o_stencilWriteAdr       = o_adr;
  assign o_stencilWriteValue     = o_command ? {PIX_PER_BLK{force_bit}} : '0;
  assign o_stencilWriteMask      = o_writeMask;
endmodule

// File: tb/tb_gpu_fill_engine_param.sv
// Scoreboard bench for gpu_fill_engine_param at default parameters (16 px/block, 1024x512).
module tb_gpu_fill_engine_param;
  localparam int PPB = 16;
  localparam int AW  = 15;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic i_nrst, i_activateFILL, i_exactMode, i_forceMask, i_InterlaceRender, field_in, i_busy;
  logic [7:0] r0, g0, b0;
  logic [11:0] x0, y0;
  logic [10:0] sw;
  logic [9:0]  sh;
  logic o_inact, o_command, o_write, o_ssig;
  logic [AW-1:0] o_adr, o_sadr;
  logic [PPB-1:0] o_mask, o_sval, o_smask;
  logic [16*PPB-1:0] o_data;

  gpu_fill_engine_param dut (
    .i_clk(clk), .i_nrst(i_nrst), .i_activateFILL(i_activateFILL), .i_exactMode(i_exactMode),
    .i_forceMask(i_forceMask), .i_InterlaceRender(i_InterlaceRender),
    .GPU_REG_CurrentInterlaceField(field_in), .RegR0(r0), .RegG0(g0), .RegB0(b0),
    .RegX0(x0), .RegY0(y0), .RegSizeW(sw), .RegSizeH(sh),
    .o_FILLInactiveNextCycle(o_inact), .o_command(o_command), .i_busy(i_busy),
    .o_write(o_write), .o_adr(o_adr), .o_writeMask(o_mask), .o_dataOut(o_data),
    .o_stencilWriteSig(o_ssig), .o_stencilWriteAdr(o_sadr),
    .o_stencilWriteValue(o_sval), .o_stencilWriteMask(o_smask)
  );

  typedef struct packed { logic [AW-1:0] adr; logic [PPB-1:0] mask; } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  logic [15:0] exp_pix;
  logic        exp_force;
  int first_cyc, done_cyc, pulses;

  task set_regs(input int x, input int y, input int w, input int h, input logic exact,
                input logic il, input logic fld, input logic [7:0] r, input logic [7:0] g,
                input logic [7:0] b, input logic frc);
    x0 = 12'(x); y0 = 12'(y); sw = 11'(w); sh = 10'(h);
    i_exactMode = exact; i_InterlaceRender = il; field_in = fld;
    r0 = r; g0 = g; b0 = b; i_forceMask = frc;
    exp_pix   = {frc, b[7:3], g[7:3], r[7:3]};
    exp_force = frc;
  endtask

  task push(input logic [AW-1:0] a, input logic [PPB-1:0] m);
    exp_t e;
    e.adr = a; e.mask = m;
    q.push_back(e);
  endtask

  // Pulses activate, then follows the fill cycle by cycle; cycle 1 is the cycle after activate.
  task run_fill(input int busy_hold, output int f_cyc, output int d_cyc, output int n_pulse);
    int cyc, held;
    bit done;
    exp_t e;
    logic [AW-1:0] h_adr;
    logic [PPB-1:0] h_mask;
    f_cyc = -1; d_cyc = -1; n_pulse = 0; held = 0; done = 0;
    h_adr = '0; h_mask = '0;
    @(negedge clk); i_activateFILL = 1'b1;
    @(posedge clk); #1; i_activateFILL = 1'b0; cyc = 1;
    while (!done && cyc < 300) begin
      i_busy = 1'b0;
      if (o_command && held < busy_hold) begin
        i_busy = 1'b1;
        if (held == 0) begin
          h_adr = o_adr; h_mask = o_writeMask_s();
        end else begin
          checks++;
          if (o_adr !== h_adr || o_mask !== h_mask || o_command !== 1'b1) begin
            errors++;
            $display("FAIL busy_stable cyc %0d: adr %h mask %h, required adr %h mask %h", cyc, o_adr, o_mask, h_adr, h_mask);
          end
        end
        held++;
      end
      #1;
      if (o_command && f_cyc < 0) f_cyc = cyc;
      if (o_ssig) n_pulse++;
      if (o_command && !i_busy) begin
        checks++;
        if (q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_req cyc %0d: adr %h mask %h, required none", cyc, o_adr, o_mask);
        end else begin
          e = q.pop_front();
          if (o_adr !== e.adr || o_mask !== e.mask || o_data !== {PPB{exp_pix}} || o_write !== 1'b1 ||
              o_ssig !== 1'b1 || o_sadr !== e.adr || o_smask !== e.mask || o_sval !== {PPB{exp_force}}) begin
            errors++;
            $display("FAIL request cyc %0d: adr %h mask %h pix %h ssig %b sadr %h smask %h sval %h, required adr %h mask %h pix %h sval %h",
                     cyc, o_adr, o_mask, o_data[15:0], o_ssig, o_sadr, o_smask, o_sval,
                     e.adr, e.mask, exp_pix, {PPB{exp_force}});
          end
        end
      end else begin
        checks++;
        if (o_ssig !== 1'b0) begin
          errors++;
          $display("FAIL stencil_idle cyc %0d: sig %b, required 0", cyc, o_ssig);
        end
      end
      if (o_inact && !o_command) begin
        done = 1; d_cyc = cyc;
      end else begin
        @(posedge clk); #1; cyc++;
      end
    end
    i_busy = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL fill_timeout: no DONE within %0d cycles", cyc);
    end
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL leftover_req: %0d expected requests never issued, required 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  function automatic logic [PPB-1:0] o_writeMask_s();
    return o_mask;
  endfunction

  task expect_int(input string name, input int act, input int req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0d, required %0d", name, act, req);
    end
  endtask

  task test_reset;
    i_nrst = 1'b0; i_activateFILL = 1'b0; i_busy = 1'b0;
    set_regs(0, 0, 0, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00, 0);
    #3;
    checks++;
    if (o_command !== 1'b0 || o_ssig !== 1'b0 || o_mask !== '0 || o_adr !== '0 ||
        o_data !== '0 || o_inact !== 1'b1) begin
      errors++;
      $display("FAIL reset_state: cmd %b ssig %b mask %h adr %h inact %b, required 0 0 0 0 1",
               o_command, o_ssig, o_mask, o_adr, o_inact);
    end
    @(negedge clk); i_nrst = 1'b1;
    @(negedge clk);
  endtask

  task test_basic;
    set_regs(0, 0, 16, 2, 0, 0, 0, 8'hF8, 8'h00, 8'h00, 1);
    push(15'h0000, 16'hFFFF);
    push(15'h0040, 16'hFFFF);
    run_fill(0, first_cyc, done_cyc, pulses);
    expect_int("basic_first_cyc", first_cyc, 3);
    expect_int("basic_done_cyc", done_cyc, 6);
    expect_int("basic_pulses", pulses, 2);
  endtask

  task test_exact;
    set_regs(5, 0, 20, 1, 1, 0, 0, 8'h08, 8'h10, 8'h18, 0);
    push(15'h0000, 16'hFFE0);
    push(15'h0001, 16'h01FF);
    run_fill(0, first_cyc, done_cyc, pulses);
    expect_int("exact_done_cyc", done_cyc, 5);
    set_regs(5, 0, 20, 1, 0, 0, 0, 8'hFF, 8'h80, 8'h40, 1);
    push(15'h0000, 16'hFFFF);
    push(15'h0001, 16'hFFFF);
    run_fill(0, first_cyc, done_cyc, pulses);
    expect_int("rounded_pulses", pulses, 2);
  endtask

  task test_wrap;
    set_regs(-16, 511, 32, 2, 0, 0, 0, 8'h55, 8'hAA, 8'h33, 0);
    push(15'h7FFF, 16'hFFFF);
    push(15'h7FC0, 16'hFFFF);
    push(15'h003F, 16'hFFFF);
    push(15'h0000, 16'hFFFF);
    run_fill(0, first_cyc, done_cyc, pulses);
    expect_int("wrap_pulses", pulses, 4);
  endtask

  task test_interlace_and_empty;
    set_regs(0, 10, 16, 4, 0, 1, 0, 8'h10, 8'h20, 8'h30, 0);
    push(15'h02C0, 16'hFFFF);
    push(15'h0340, 16'hFFFF);
    run_fill(0, first_cyc, done_cyc, pulses);
    expect_int("interlace_done_cyc", done_cyc, 8);
    set_regs(0, 0, 0, 4, 0, 0, 0, 8'h10, 8'h20, 8'h30, 0);
    run_fill(0, first_cyc, done_cyc, pulses);
    expect_int("w0_done_cyc", done_cyc, 2);
    expect_int("w0_no_cmd", first_cyc, -1);
  endtask

  task test_backpressure;
    set_regs(0, 0, 32, 1, 0, 0, 0, 8'hC0, 8'h60, 8'h18, 1);
    push(15'h0000, 16'hFFFF);
    push(15'h0001, 16'hFFFF);
    run_fill(7, first_cyc, done_cyc, pulses);
    expect_int("bp_first_cyc", first_cyc, 3);
    expect_int("bp_pulses", pulses, 2);
    expect_int("bp_done_cyc", done_cyc, 12);
  endtask

  task test_reset_mid_fill;
    set_regs(0, 0, 32, 2, 0, 0, 0, 8'hFF, 8'hFF, 8'hFF, 0);
    @(negedge clk); i_activateFILL = 1'b1; i_busy = 1'b1;
    @(posedge clk); #1; i_activateFILL = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    expect_int("midfill_cmd_before", int'(o_command), 1);
    #2; i_nrst = 1'b0; #1;
    checks++;
    if (o_command !== 1'b0 || o_ssig !== 1'b0 || o_adr !== '0 || o_mask !== '0 || o_inact !== 1'b1) begin
      errors++;
      $display("FAIL midfill_reset: cmd %b ssig %b adr %h mask %h inact %b, required 0 0 0 0 1",
               o_command, o_ssig, o_adr, o_mask, o_inact);
    end
    @(negedge clk); i_nrst = 1'b1; i_busy = 1'b0;
    repeat (2) @(negedge clk);
    expect_int("post_reset_idle", int'(o_command), 0);
    test_basic();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_exact();
    test_wrap();
    test_interlace_and_empty();
    test_backpressure();
    test_reset_mid_fill();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
